// File: rtl/ysyx_24080006_if_stage_if.sv
// Fetch-stage bus bundle: AXI4-Lite read channels, the fetch->decode
// valid/ready handshake and the next-PC pulse from write-back.
// The master modport is the fetch stage, the slave modport is its environment
// (memory slave, decode stage and write-back stage together).
interface ysyx_24080006_if_stage_if;
  // AXI4-Lite read address / read data channels
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  // fetch -> decode
  logic        ifu2idu_valid;
  logic [31:0] ifu2idu_pc;
  logic [31:0] ifu2idu_inst;
  logic        ifu2idu_fault;
  logic        idu2ifu_ready;
  // write-back -> fetch
  logic        wbu2ifu_valid;
  logic [31:0] wbu2ifu_dnpc;

  modport master (
    output araddr, arvalid, rready,
    output ifu2idu_valid, ifu2idu_pc, ifu2idu_inst, ifu2idu_fault,
    input  arready, rdata, rresp, rvalid,
    input  idu2ifu_ready,
    input  wbu2ifu_valid, wbu2ifu_dnpc
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  ifu2idu_valid, ifu2idu_pc, ifu2idu_inst, ifu2idu_fault,
    output arready, rdata, rresp, rvalid,
    output idu2ifu_ready,
    output wbu2ifu_valid, wbu2ifu_dnpc
  );
endinterface

// File: rtl/ysyx_24080006_if_stage.sv
// Instruction fetch stage of the multi-cycle core.
// One AXI4-Lite read per instruction at the current PC; the returned word,
// its PC and a fault flag are held toward decode until accepted, then the
// stage idles until write-back supplies the next PC. Only one instruction is
// ever in flight. All outputs come straight from flops.
// Optional feature macro: IFU_PERF_EN enables the fetch performance counters;
// when undefined both perf ports are tied to zero and no counter flops exist.
module ysyx_24080006_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                            clock,
  input  logic                            reset,
  ysyx_24080006_if_stage_if.master        bus,
  output logic [31:0]                     perf_fetch_cnt,
  output logic [31:0]                     perf_fetch_cycles
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_AR      = 2'd0,
    ST_R       = 2'd1,
    ST_HOLD    = 2'd2,
    ST_WAIT_PC = 2'd3
  } state_t;

  // Word-aligned bus address for a (possibly misaligned) PC.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    word_align = {addr[31:2], 2'b00};
  endfunction

  // A fetch faults on a bus error response or on a misaligned PC.
  function automatic logic fetch_fault(input logic [1:0] resp, input logic [31:0] pc);
    fetch_fault = (resp != 2'b00) || (pc[1:0] != 2'b00);
  endfunction

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] araddr_r, araddr_s;
  logic        arvalid_r, arvalid_s;
  logic        rready_r, rready_s;
  logic        valid_r, valid_s;
  logic [31:0] out_pc_r, out_pc_s;
  logic [31:0] inst_r, inst_s;
  logic        fault_r, fault_s;

  logic ar_fire_s;
  logic r_fire_s;
  logic id_fire_s;
  logic wb_fire_s;

  // Handshake events are only honoured in the state that expects them; an
  // early rvalid, a stray arready or an off-state wbu pulse is ignored.
  assign ar_fire_s = (state_r == ST_AR)      && arvalid_r && bus.arready;
  assign r_fire_s  = (state_r == ST_R)       && rready_r  && bus.rvalid;
  assign id_fire_s = (state_r == ST_HOLD)    && valid_r   && bus.idu2ifu_ready;
  assign wb_fire_s = (state_r == ST_WAIT_PC) && bus.wbu2ifu_valid;

  // State register with synchronous reset back to the address phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_AR;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode: each state advances only on its own handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_AR: begin
        if (ar_fire_s) begin
          state_s = ST_R;
        end else begin
          state_s = ST_AR;
        end
      end
      ST_R: begin
        if (r_fire_s) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_R;
        end
      end
      ST_HOLD: begin
        if (id_fire_s) begin
          state_s = ST_WAIT_PC;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_WAIT_PC: begin
        if (wb_fire_s) begin
          state_s = ST_AR;
        end else begin
          state_s = ST_WAIT_PC;
        end
      end
      default: begin
        state_s = ST_AR;
      end
    endcase
  end

  // Next values of the registered outputs and the PC, decided from the
  // current state and the handshake that completes in it this cycle.
  always_comb begin
    pc_s      = pc_r;
    araddr_s  = araddr_r;
    arvalid_s = arvalid_r;
    rready_s  = rready_r;
    valid_s   = valid_r;
    out_pc_s  = out_pc_r;
    inst_s    = inst_r;
    fault_s   = fault_r;
    case (state_r)
      ST_AR: begin
        // arvalid rises on the first AR cycle and stays up until accepted.
        if (ar_fire_s) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
        end else begin
          arvalid_s = 1'b1;
          rready_s  = 1'b0;
        end
      end
      ST_R: begin
        // A faulting word is still captured and presented; decode traps it.
        if (r_fire_s) begin
          rready_s = 1'b0;
          valid_s  = 1'b1;
          out_pc_s = pc_r;
          inst_s   = bus.rdata;
          fault_s  = fetch_fault(bus.rresp, pc_r);
        end else begin
          rready_s = 1'b1;
        end
      end
      ST_HOLD: begin
        // Presented fields stay frozen until decode takes them.
        if (id_fire_s) begin
          valid_s = 1'b0;
        end else begin
          valid_s = 1'b1;
        end
      end
      ST_WAIT_PC: begin
        if (wb_fire_s) begin
          pc_s      = bus.wbu2ifu_dnpc;
          araddr_s  = word_align(bus.wbu2ifu_dnpc);
          arvalid_s = 1'b1;
        end else begin
          arvalid_s = 1'b0;
        end
      end
      default: begin
        arvalid_s = 1'b0;
        rready_s  = 1'b0;
        valid_s   = 1'b0;
      end
    endcase
  end

  // Output and PC registers; reset abandons any outstanding read.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r      <= RESET_PC;
      araddr_r  <= RESET_PC;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      valid_r   <= 1'b0;
      out_pc_r  <= RESET_PC;
      inst_r    <= NOP_INST;
      fault_r   <= 1'b0;
    end else begin
      pc_r      <= pc_s;
      araddr_r  <= araddr_s;
      arvalid_r <= arvalid_s;
      rready_r  <= rready_s;
      valid_r   <= valid_s;
      out_pc_r  <= out_pc_s;
      inst_r    <= inst_s;
      fault_r   <= fault_s;
    end
  end

  assign bus.araddr        = araddr_r;
  assign bus.arvalid       = arvalid_r;
  assign bus.rready        = rready_r;
  assign bus.ifu2idu_valid = valid_r;
  assign bus.ifu2idu_pc    = out_pc_r;
  assign bus.ifu2idu_inst  = inst_r;
  assign bus.ifu2idu_fault = fault_r;

`ifdef IFU_PERF_EN
  logic [31:0] perf_cnt_r;
  logic [31:0] perf_cyc_r;

  // Count completed fetches and cycles spent on the bus (AR or R); both wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cnt_r <= 32'd0;
      perf_cyc_r <= 32'd0;
    end else begin
      if (r_fire_s) begin
        perf_cnt_r <= perf_cnt_r + 32'd1;
      end else begin
        perf_cnt_r <= perf_cnt_r;
      end
      if ((state_r == ST_AR) || (state_r == ST_R)) begin
        perf_cyc_r <= perf_cyc_r + 32'd1;
      end else begin
        perf_cyc_r <= perf_cyc_r;
      end
    end
  end

  assign perf_fetch_cnt    = perf_cnt_r;
  assign perf_fetch_cycles = perf_cyc_r;
`else
  assign perf_fetch_cnt    = 32'd0;
  assign perf_fetch_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_24080006_if_stage.sv
// Self-checking bench for ysyx_24080006_if_stage: table of fetch vectors,
// hand-written corner sequences and randomized fetches checked against a
// small arithmetic reference model.
module tb_ysyx_24080006_if_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_fetch_cycles;

  ysyx_24080006_if_stage_if bus();

  ysyx_24080006_if_stage #(.RESET_PC(RESET_PC)) dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (bus),
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_fetch_cycles (perf_fetch_cycles)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned exp_cnt  = 0;
  int unsigned exp_cyc  = 0;

  typedef struct packed {
    logic [31:0] dnpc;
    int          ar_dly;
    int          r_dly;
    int          acc_dly;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        junk;
    logic        ready_early;
    logic [31:0] exp_araddr;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [7];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_perf(input string name);
`ifdef IFU_PERF_EN
    chk32({name, "_perf_cnt"}, perf_fetch_cnt, exp_cnt);
    chk32({name, "_perf_cyc"}, perf_fetch_cycles, exp_cyc);
`else
    chk32({name, "_perf_cnt"}, perf_fetch_cnt, 32'd0);
    chk32({name, "_perf_cyc"}, perf_fetch_cycles, 32'd0);
`endif
  endtask

  // Reference model: aligned address and fault rule from plain arithmetic.
  function automatic logic [31:0] model_addr(input logic [31:0] pc);
    model_addr = pc - (pc % 32'd4);
  endfunction

  function automatic logic model_fault(input logic [31:0] pc, input logic [1:0] resp);
    model_fault = (resp != 2'b00) || ((pc % 32'd4) != 32'd0);
  endfunction

  // One write-back pulse; called at a negedge, returns at the next negedge.
  task automatic do_wbu(input logic [31:0] dnpc);
    bus.wbu2ifu_valid = 1'b1;
    bus.wbu2ifu_dnpc  = dnpc;
    @(negedge clock);
    bus.wbu2ifu_valid = 1'b0;
  endtask

  // Plays the memory slave for one fetch and checks the presented result.
  task automatic do_fetch(input int exp_wait, input int ar_dly, input int r_dly,
                          input logic [31:0] data, input logic [1:0] resp,
                          input logic junk, input logic ready_early,
                          input logic [31:0] exp_araddr, input logic [31:0] exp_pc,
                          input logic exp_fault);
    int waited = 0;
    while (bus.arvalid !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk32("arvalid_wait", waited, exp_wait);
    chk1("arvalid_up", bus.arvalid, 1'b1);
    chk32("araddr", bus.araddr, exp_araddr);
    for (int i = 0; i < ar_dly; i++) begin
      if (junk) begin
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hBAD0_BAD0;
      end
      @(negedge clock);
      chk1("arvalid_hold", bus.arvalid, 1'b1);
      chk1("rready_lo_in_ar", bus.rready, 1'b0);
    end
    bus.rvalid  = 1'b0;
    bus.arready = 1'b1;
    @(negedge clock);
    bus.arready = 1'b0;
    chk1("arvalid_drop", bus.arvalid, 1'b0);
    chk1("rready_up", bus.rready, 1'b1);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clock);
      chk1("rready_hold", bus.rready, 1'b1);
      chk1("valid_lo_in_r", bus.ifu2idu_valid, 1'b0);
    end
    bus.rvalid = 1'b1;
    bus.rdata  = data;
    bus.rresp  = resp;
    if (ready_early) bus.idu2ifu_ready = 1'b1;
    @(negedge clock);
    bus.rvalid = 1'b0;
    bus.rresp  = 2'b00;
    chk1("rready_drop", bus.rready, 1'b0);
    chk1("valid_up", bus.ifu2idu_valid, 1'b1);
    chk32("out_pc", bus.ifu2idu_pc, exp_pc);
    chk32("out_inst", bus.ifu2idu_inst, data);
    chk1("out_fault", bus.ifu2idu_fault, exp_fault);
    exp_cnt = exp_cnt + 1;
    exp_cyc = exp_cyc + exp_wait + ar_dly + r_dly + 2;
    chk_perf("fetch");
  endtask

  // Plays decode: stalls dly cycles, accepts once, then expects idling.
  task automatic do_accept(input int dly, input logic [31:0] exp_pc,
                           input logic [31:0] exp_inst, input logic exp_fault);
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      chk1("stall_valid", bus.ifu2idu_valid, 1'b1);
      chk32("stall_pc", bus.ifu2idu_pc, exp_pc);
      chk32("stall_inst", bus.ifu2idu_inst, exp_inst);
      chk1("stall_fault", bus.ifu2idu_fault, exp_fault);
    end
    bus.idu2ifu_ready = 1'b1;
    @(negedge clock);
    bus.idu2ifu_ready = 1'b0;
    chk1("accept_valid_drop", bus.ifu2idu_valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk1("idle_arvalid", bus.arvalid, 1'b0);
      chk1("idle_valid", bus.ifu2idu_valid, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] rdat;
    logic [1:0]  rrsp;
    int          ard, rd, acd;

    vecs[0] = '{dnpc:32'h8000_0010, ar_dly:0, r_dly:0, acc_dly:1, rdata:32'h00A0_0093, rresp:2'b00,
                junk:1'b0, ready_early:1'b0, exp_araddr:32'h8000_0010, exp_fault:1'b0};
    vecs[1] = '{dnpc:32'h8000_0014, ar_dly:1, r_dly:1, acc_dly:0, rdata:32'hDEAD_BEEF, rresp:2'b10,
                junk:1'b0, ready_early:1'b0, exp_araddr:32'h8000_0014, exp_fault:1'b1};
    vecs[2] = '{dnpc:32'h8000_0002, ar_dly:0, r_dly:0, acc_dly:0, rdata:32'h1234_5678, rresp:2'b00,
                junk:1'b0, ready_early:1'b0, exp_araddr:32'h8000_0000, exp_fault:1'b1};
    vecs[3] = '{dnpc:32'h8000_0100, ar_dly:4, r_dly:3, acc_dly:1, rdata:32'h0010_0073, rresp:2'b00,
                junk:1'b1, ready_early:1'b0, exp_araddr:32'h8000_0100, exp_fault:1'b0};
    vecs[4] = '{dnpc:32'h8000_0203, ar_dly:2, r_dly:0, acc_dly:0, rdata:32'hCAFE_F00D, rresp:2'b01,
                junk:1'b0, ready_early:1'b1, exp_araddr:32'h8000_0200, exp_fault:1'b1};
    vecs[5] = '{dnpc:32'h8000_0FFC, ar_dly:0, r_dly:2, acc_dly:2, rdata:32'h0000_8067, rresp:2'b11,
                junk:1'b0, ready_early:1'b0, exp_araddr:32'h8000_0FFC, exp_fault:1'b1};
    vecs[6] = '{dnpc:32'hFFFF_FFFC, ar_dly:1, r_dly:0, acc_dly:0, rdata:32'h0000_0001, rresp:2'b00,
                junk:1'b0, ready_early:1'b0, exp_araddr:32'hFFFF_FFFC, exp_fault:1'b0};

    reset             = 1'b1;
    bus.arready       = 1'b0;
    bus.rvalid        = 1'b0;
    bus.rdata         = 32'd0;
    bus.rresp         = 2'b00;
    bus.idu2ifu_ready = 1'b0;
    bus.wbu2ifu_valid = 1'b0;
    bus.wbu2ifu_dnpc  = 32'd0;

    // Reset values
    repeat (3) @(negedge clock);
    chk1("rst_arvalid", bus.arvalid, 1'b0);
    chk32("rst_araddr", bus.araddr, RESET_PC);
    chk1("rst_rready", bus.rready, 1'b0);
    chk1("rst_valid", bus.ifu2idu_valid, 1'b0);
    chk32("rst_pc", bus.ifu2idu_pc, RESET_PC);
    chk32("rst_inst", bus.ifu2idu_inst, NOP_INST);
    chk1("rst_fault", bus.ifu2idu_fault, 1'b0);
    chk_perf("rst");

    // First fetch after reset: arvalid one cycle after release, valid at cycle 3.
    reset = 1'b0;
    do_fetch(1, 0, 0, 32'h0000_0297, 2'b00, 1'b0, 1'b0, RESET_PC, RESET_PC, 1'b0);
    do_accept(5, RESET_PC, 32'h0000_0297, 1'b0);

    // arready while arvalid is low is ignored.
    bus.arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk1("stray_arready_arvalid", bus.arvalid, 1'b0);
      chk1("stray_arready_rready", bus.rready, 1'b0);
    end
    bus.arready = 1'b0;

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      do_wbu(vecs[i].dnpc);
      do_fetch(0, vecs[i].ar_dly, vecs[i].r_dly, vecs[i].rdata, vecs[i].rresp,
               vecs[i].junk, vecs[i].ready_early, vecs[i].exp_araddr,
               vecs[i].dnpc, vecs[i].exp_fault);
      do_accept(vecs[i].acc_dly, vecs[i].dnpc, vecs[i].rdata, vecs[i].exp_fault);
    end

    // wbu pulse during HOLD is ignored: fields stable, no new fetch, PC kept.
    do_wbu(32'h8000_0040);
    do_fetch(0, 0, 0, 32'h0000_0517, 2'b00, 1'b0, 1'b0, 32'h8000_0040, 32'h8000_0040, 1'b0);
    do_wbu(32'h1234_5670);
    chk1("hold_wbu_valid", bus.ifu2idu_valid, 1'b1);
    chk32("hold_wbu_pc", bus.ifu2idu_pc, 32'h8000_0040);
    chk1("hold_wbu_arvalid", bus.arvalid, 1'b0);
    do_accept(1, 32'h8000_0040, 32'h0000_0517, 1'b0);
    do_wbu(32'h8000_0044);
    do_fetch(0, 0, 0, 32'h0000_0013, 2'b00, 1'b0, 1'b0, 32'h8000_0044, 32'h8000_0044, 1'b0);
    do_accept(0, 32'h8000_0044, 32'h0000_0013, 1'b0);

    // Randomized fetches against the reference model
    for (int i = 0; i < 20; i++) begin
      rpc  = $urandom;
      rdat = $urandom;
      rrsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ard  = $urandom_range(0, 3);
      rd   = $urandom_range(0, 3);
      acd  = $urandom_range(0, 3);
      do_wbu(rpc);
      do_fetch(0, ard, rd, rdat, rrsp, 1'b0, 1'b0, model_addr(rpc), rpc, model_fault(rpc, rrsp));
      do_accept(acd, rpc, rdat, model_fault(rpc, rrsp));
    end

    // Reset while in R abandons the read and restarts at RESET_PC.
    do_wbu(32'h8000_0080);
    chk1("mid_r_arvalid", bus.arvalid, 1'b1);
    bus.arready = 1'b1;
    @(negedge clock);
    bus.arready = 1'b0;
    chk1("mid_r_rready", bus.rready, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk1("post_rst_arvalid", bus.arvalid, 1'b0);
    chk1("post_rst_rready", bus.rready, 1'b0);
    chk1("post_rst_valid", bus.ifu2idu_valid, 1'b0);
    chk32("post_rst_araddr", bus.araddr, RESET_PC);
    exp_cnt = 0;
    exp_cyc = 0;
    chk_perf("post_rst");
    do_fetch(1, 0, 1, 32'h0000_0517, 2'b00, 1'b0, 1'b0, RESET_PC, RESET_PC, 1'b0);
    do_accept(0, RESET_PC, 32'h0000_0517, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_if_stage.md
# ysyx_24080006_if_stage

Instruction fetch stage of the multi-cycle core: the producer end of the fetch→decode valid/ready handshake whose consumer is the decode stage. Issues one AXI4-Lite read per instruction at the current PC, holds the returned word and its PC valid toward decode until accepted, then waits for the next PC from write-back before fetching again. Exactly one instruction is in flight at any time.

## Interface
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- araddr  out  32  AXI4-Lite read address (always word-aligned)
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready
- rdata  in  32  read data
- rresp  in  2  read response; nonzero = access fault
- rvalid  in  1  read-data valid
- rready  out  1  read-data ready
- ifu2idu_valid  out  1  instruction valid toward decode
- ifu2idu_pc  out  32  PC of presented instruction
- ifu2idu_inst  out  32  presented instruction word
- ifu2idu_fault  out  1  fetch access fault (rresp != 0) or misaligned PC
- idu2ifu_ready  in  1  decode ready (registered on decode side)
- wbu2ifu_valid  in  1  next-PC valid from write-back, 1-cycle pulse
- wbu2ifu_dnpc  in  32  next PC
- perf_fetch_cnt  out  32  completed fetches (see Configuration)
- perf_fetch_cycles  out  32  cycles spent in AR+R states (see Configuration)

## Operation
- States: AR, R, HOLD, WAIT_PC. All outputs registered.
- AR: arvalid=1, araddr={pc[31:2],2'b00}. On arvalid&&arready → R, arvalid←0, rready←1.
- R: on rvalid&&rready → HOLD; capture inst←rdata, fault←(rresp!=0)|(pc[1:0]!=0); rready←0, ifu2idu_valid←1.
- HOLD: ifu2idu_valid, _pc, _inst, _fault held stable. On ifu2idu_valid&&idu2ifu_ready → WAIT_PC, valid←0.
- WAIT_PC: on wbu2ifu_valid → pc←wbu2ifu_dnpc, AR, arvalid←1.
- wbu2ifu_valid outside WAIT_PC is ignored (protocol violation; bench flags it).
- arvalid never deasserts before arready; ifu2idu_valid never deasserts before handshake (AXI/ready-valid stability).
- Fault does not stall: faulting word is still presented; decode/trap logic handles it.

## Timing
- Reset values: state=AR, pc=RESET_PC, arvalid=0, araddr=RESET_PC, rready=0, ifu2idu_valid=0, ifu2idu_pc=RESET_PC, ifu2idu_inst=32'h0000_0013 (nop), ifu2idu_fault=0, perf counters=0.
- First cycle after reset release: arvalid rises (registered from AR state).
- Best case wbu2ifu_valid → ifu2idu_valid: 3 cycles (AR entry 1, arready same cycle, rvalid next cycle, valid registered).
- Back-to-back: arready and rvalid in consecutive cycles accepted; arready while arvalid=0 ignored.
- rvalid arriving in AR (before address handshake) is ignored.
- Reset mid-transaction: any outstanding AXI read is abandoned; the bus slave must also be reset; fetch restarts at RESET_PC.
- ifu2idu_valid high with idu2ifu_ready high at HOLD entry: handshake completes in that first HOLD cycle.

## Configuration
- IFU_PERF_EN defined: perf_fetch_cnt increments by 1 on each R→HOLD transition; perf_fetch_cycles increments every cycle in AR or R. Both wrap at 2^32, clear on reset.
- IFU_PERF_EN undefined: both ports driven constant 0, no counter flops.

## Test plan
- Reset release, slave arready=1 immediately, rvalid next cycle with rdata=32'h0000_0297, rresp=0 → araddr=32'h8000_0000, ifu2idu_valid at cycle 3, pc=32'h8000_0000, inst=32'h0000_0297, fault=0.
- Decode holds idu2ifu_ready=0 for 5 cycles → valid/pc/inst stable all 5 cycles; single handshake when ready rises; then no arvalid until wbu2ifu_valid.
- wbu2ifu_valid with dnpc=32'h8000_0010 → next araddr=32'h8000_0010; pulse during HOLD instead → ignored, pc unchanged.
- rresp=2'b10 with rdata=32'hDEAD_BEEF → ifu2idu_fault=1, inst=32'hDEAD_BEEF presented; dnpc=32'h8000_0002 → araddr=32'h8000_0000, fault=1.
- arready delayed 4 cycles, rvalid delayed 3 → arvalid held 5 cycles, rready high until rvalid; with IFU_PERF_EN, perf_fetch_cycles=+9 and perf_fetch_cnt=+1; without, both 0.
- Assert reset while in R → next cycle state AR, arvalid=0, rready=0, ifu2idu_valid=0; fetch restarts at 32'h8000_0000.
